// File: rtl/uart_ctrl.sv
// uart_ctrl: multi-cycle controller for the board's parallel UART, which shares
// the RAM1 data bus. One access per request. Data register 0xBF00 (sel=0) and
// status register 0xBF01 (sel=1).
//
// Optional feature macro: UART_RX_FIFO_EN
//   Adds an RX_DEPTH-entry receive FIFO that is drained from the chip in the
//   background while IDLE. The default build (macro undefined) reads the chip
//   directly on every data read.
//
// Handshake: uci_req is a level held by the mem stage. While uco_busy=1 the
// pipeline stalls. The access ends with a one-cycle uco_done pulse, and
// uco_rdata is valid in that cycle. The mem stage drops uci_req in the done
// cycle. uci_req is sampled only in IDLE.
//
// Ports:
//   uci_clk, uci_rst            clock, asynchronous active-low reset
//   uci_req/we/sel/wdata        request from the mem stage
//   uco_rdata/done/busy         result, completion pulse, stall request
//   uci_uart_tbre/tsre/data_ready  UART status pins
//   uco_uart_wrn/rdn            UART strobes, active-low
//   uco_bus_oe/bus_wdata        RAM1 data bus drive enable and value
//   uci_bus_rdata               RAM1 data bus sample
//   uco_ram1_en                 RAM1 chip enable, active-low, always disabled here
//   uco_dbg_state               current FSM state, for checkers
module uart_ctrl #(
  parameter int WR_PULSE = 2,
  parameter int RD_PULSE = 2,
  parameter int RX_DEPTH = 4
) (
  input  logic        uci_clk,
  input  logic        uci_rst,
  input  logic        uci_req,
  input  logic        uci_we,
  input  logic        uci_sel,
  input  logic [15:0] uci_wdata,
  output logic [15:0] uco_rdata,
  output logic        uco_done,
  output logic        uco_busy,
  input  logic        uci_uart_tbre,
  input  logic        uci_uart_tsre,
  input  logic        uci_uart_data_ready,
  output logic        uco_uart_wrn,
  output logic        uco_uart_rdn,
  output logic        uco_bus_oe,
  output logic [15:0] uco_bus_wdata,
  input  logic [15:0] uci_bus_rdata,
  output logic        uco_ram1_en,
  output logic [2:0]  uco_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_STB  = 3'd1,
    S_WR_TBRE = 3'd2,
    S_WR_TSRE = 3'd3,
    S_RD_STB  = 3'd4,
    S_RD_SMP  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [3:0] WR_LAST = 4'(WR_PULSE - 1);
  localparam logic [3:0] RD_LAST = 4'(RD_PULSE - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] rdata_q;
  logic [7:0]  wbyte_q;
  logic        tx_ready;
  logic        rx_flag;
  logic        data_req;

  // Upper bus/write bytes are never used by a byte-wide UART.
  logic unused_bits;
  assign unused_bits = ^{uci_wdata[15:8], uci_bus_rdata[15:8], 1'(RX_DEPTH)};

  assign tx_ready = uci_uart_tbre & uci_uart_tsre;
  assign data_req = uci_req & ~uci_we & ~uci_sel;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_DEPTH);

  logic [7:0]  fifo_mem [RX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        auto_q;
  logic        push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A background chip read ends in RD_SMP with auto_q set; a host data read pops in IDLE.
  assign push       = (state_q == S_RD_SMP) && auto_q;
  assign pop        = (state_q == S_IDLE) && data_req && !fifo_empty;
  assign rx_flag    = !fifo_empty;

  always_ff @(posedge uci_clk or negedge uci_rst) begin
    if (!uci_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      auto_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Decided every IDLE cycle; a request always wins over a background read.
      if (state_q == S_IDLE)
        auto_q <= !uci_req && uci_uart_data_ready && !fifo_full;
    end
  end

  always_ff @(posedge uci_clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= uci_bus_rdata[7:0];
  end
`else
  assign rx_flag = uci_uart_data_ready;
`endif

  // State register, strobe counter and result registers.
  always_ff @(posedge uci_clk or negedge uci_rst) begin
    if (!uci_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      wbyte_q <= '0;
    end else begin
      state_q <= state_d;
      // Counter restarts on every state change, so it is zero on strobe entry.
      if (state_d != state_q) cnt_q <= '0;
      else if (state_q == S_WR_STB || state_q == S_RD_STB) cnt_q <= cnt_q + 4'd1;

      if (state_q == S_IDLE && uci_req) begin
        if (uci_sel) begin
          rdata_q <= {14'b0, rx_flag, tx_ready};
        end else if (uci_we) begin
          wbyte_q <= uci_wdata[7:0];
        end else begin
`ifdef UART_RX_FIFO_EN
          rdata_q <= fifo_empty ? 16'h0000 : {8'h00, fifo_mem[rd_ptr[AW-1:0]]};
`else
          if (!uci_uart_data_ready) rdata_q <= 16'h0000;
`endif
        end
      end
`ifdef UART_RX_FIFO_EN
      if (state_q == S_RD_SMP && !auto_q) rdata_q <= {8'h00, uci_bus_rdata[7:0]};
`else
      if (state_q == S_RD_SMP) rdata_q <= {8'h00, uci_bus_rdata[7:0]};
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (uci_req) begin
          if (uci_sel)     state_d = S_DONE;
          else if (uci_we) state_d = S_WR_STB;
`ifdef UART_RX_FIFO_EN
          else             state_d = S_DONE;
        end else if (uci_uart_data_ready && !fifo_full) begin
          state_d = S_RD_STB;
`else
          else if (uci_uart_data_ready) state_d = S_RD_STB;
          else             state_d = S_DONE;
`endif
        end
      end
      S_WR_STB:  if (cnt_q == WR_LAST) state_d = S_WR_TBRE;
      S_WR_TBRE: if (uci_uart_tbre)    state_d = S_WR_TSRE;
      S_WR_TSRE: if (uci_uart_tsre)    state_d = S_DONE;
      S_RD_STB:  if (cnt_q == RD_LAST) state_d = S_RD_SMP;
`ifdef UART_RX_FIFO_EN
      S_RD_SMP:  state_d = auto_q ? S_IDLE : S_DONE;
`else
      S_RD_SMP:  state_d = S_DONE;
`endif
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register, so reset releases them at once.
  always_comb begin
    uco_uart_wrn  = (state_q != S_WR_STB);
    uco_uart_rdn  = (state_q != S_RD_STB);
    uco_bus_oe    = (state_q == S_WR_STB);
    uco_bus_wdata = {8'h00, wbyte_q};
    uco_done      = (state_q == S_DONE);
    uco_rdata     = rdata_q;
    uco_ram1_en   = 1'b1;
    uco_dbg_state = state_q;
    uco_busy      = (state_q != S_IDLE && state_q != S_DONE) ||
                    (uci_req && state_q == S_IDLE);
`ifdef UART_RX_FIFO_EN
    // A background read only stalls the pipeline if a request is waiting on it.
    if (auto_q && (state_q == S_RD_STB || state_q == S_RD_SMP))
      uco_busy = uci_req;
`endif
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed testbench for uart_ctrl. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled 2 units after it.
module tb_uart_ctrl;

  logic        clk, rst_n;
  logic        req, we, sel;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        done, busy;
  logic        tbre, tsre, drv_dr, uart_dr;
  logic        wrn, rdn, bus_oe, ram1_en;
  logic [15:0] bus_wdata, drv_bus, bus_rdata;
  logic [2:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  // Results gathered by run_access.
  int          wrn_low, rdn_low, done_cnt, done_cyc, oe_bad, ram_bad;
  logic [15:0] done_rdata;
  logic [15:0] exp_wd;

  // Small UART chip model: bytes waiting in the chip, popped after a read strobe.
  logic        chip_mode;
  logic [7:0]  chip_q[$];
  logic        chip_dr, rdn_prev, pend_pop;
  logic [15:0] chip_bus;

  assign uart_dr   = chip_mode ? chip_dr  : drv_dr;
  assign bus_rdata = chip_mode ? chip_bus : drv_bus;

  uart_ctrl dut (
    .uci_clk            (clk),
    .uci_rst            (rst_n),
    .uci_req            (req),
    .uci_we             (we),
    .uci_sel            (sel),
    .uci_wdata          (wdata),
    .uco_rdata          (rdata),
    .uco_done           (done),
    .uco_busy           (busy),
    .uci_uart_tbre      (tbre),
    .uci_uart_tsre      (tsre),
    .uci_uart_data_ready(uart_dr),
    .uco_uart_wrn       (wrn),
    .uco_uart_rdn       (rdn),
    .uco_bus_oe         (bus_oe),
    .uco_bus_wdata      (bus_wdata),
    .uci_bus_rdata      (bus_rdata),
    .uco_ram1_en        (ram1_en),
    .uco_dbg_state      (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (chip_mode) begin
      if (pend_pop) begin
        void'(chip_q.pop_front());
        pend_pop = 1'b0;
      end
      if (rdn_prev == 1'b0 && rdn == 1'b1) pend_pop = 1'b1;
      rdn_prev = rdn;
    end
    chip_dr  = (chip_q.size() > 0);
    chip_bus = (chip_q.size() > 0) ? {8'hA5, chip_q[0]} : 16'h0000;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access from the mem stage: request held until done, then dropped.
  // Cycle 0 is the IDLE cycle where the request first appears.
  task automatic run_access(input logic a_we, input logic a_sel, input logic [15:0] a_wd,
                            input int tbre_at, input int tsre_at, input logic a_dr,
                            input logic [15:0] a_bus, input int ncyc);
    logic done_seen;
    done_seen = 1'b0;
    wrn_low = 0; rdn_low = 0; done_cnt = 0; done_cyc = -1; oe_bad = 0; ram_bad = 0;
    done_rdata = 16'hxxxx;
    @(posedge clk); #1;
    req = 1'b1; we = a_we; sel = a_sel; wdata = a_wd;
    drv_dr = a_dr; drv_bus = a_bus;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        req = !done_seen;
        if (done_seen) drv_dr = 1'b0;
      end
      tbre = (c >= tbre_at);
      tsre = (c >= tsre_at);
      #1;
      if (!wrn) wrn_low++;
      if (!rdn) rdn_low++;
      if (bus_oe && bus_wdata !== exp_wd) oe_bad++;
      if (ram1_en !== 1'b1) ram_bad++;
      if (done) begin
        done_cnt++;
        done_cyc   = c;
        done_rdata = rdata;
        done_seen  = 1'b1;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; sel = 1'b0; wdata = '0;
    tbre = 1'b0; tsre = 1'b0; drv_dr = 1'b0; drv_bus = '0; exp_wd = '0;
    chip_mode = 1'b0; rdn_prev = 1'b1; pend_pop = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_wrn",   16'(wrn),       16'h1);
    check("rst_rdn",   16'(rdn),       16'h1);
    check("rst_oe",    16'(bus_oe),    16'h0);
    check("rst_busy",  16'(busy),      16'h0);
    check("rst_done",  16'(done),      16'h0);
    check("rst_rdata", rdata,          16'h0000);
    check("rst_ram1",  16'(ram1_en),   16'h1);
    check("rst_state", 16'(dbg_state), 16'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Reset in the middle of a write strobe.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; sel = 1'b0; wdata = 16'h1241;
    #1; check("t1_busy_req", 16'(busy), 16'h1);
    @(posedge clk); #1;
    check("t1_wrn_low", 16'(wrn), 16'h0);
    rst_n = 1'b0; #1;
    check("t1_wrn_rel", 16'(wrn),    16'h1);
    check("t1_oe_rel",  16'(bus_oe), 16'h0);
    req = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("t1_state", 16'(dbg_state), 16'h0);
    check("t1_busy",  16'(busy),      16'h0);
    check("t1_wrn",   16'(wrn),       16'h1);

    // Write 0x1241: tbre rises at cycle 5, tsre at 8, so done lands at cycle 9.
    exp_wd = 16'h0041;
    run_access(1'b1, 1'b0, 16'h1241, 5, 8, 1'b0, 16'h0000, 14);
    check("t2_wrn_cycles", 16'(wrn_low),  16'd2);
    check("t2_wdata_bad",  16'(oe_bad),   16'd0);
    check("t2_ram1_bad",   16'(ram_bad),  16'd0);
    check("t2_done_cnt",   16'(done_cnt), 16'd1);
    check("t2_done_cyc",   16'(done_cyc), 16'd9);
    check("t2_state_end",  16'(dbg_state), 16'h0);

    // Write 0x00C3 with the transmitter already idle.
    exp_wd = 16'h00C3;
    run_access(1'b1, 1'b0, 16'hFFC3, 0, 0, 1'b0, 16'h0000, 10);
    check("t2b_wrn_cycles", 16'(wrn_low),  16'd2);
    check("t2b_wdata_bad",  16'(oe_bad),   16'd0);
    check("t2b_done_cnt",   16'(done_cnt), 16'd1);

    // Status read: tbre=1, tsre=0, data_ready=1.
    run_access(1'b0, 1'b1, 16'h0000, 0, 99, 1'b1, 16'h0000, 4);
    check("t5_done_cnt", 16'(done_cnt), 16'd1);
    check("t5_done_cyc", 16'(done_cyc), 16'd1);
`ifdef UART_RX_FIFO_EN
    check("t5_rdata",    done_rdata,    16'h0000);
`else
    check("t5_rdata",    done_rdata,    16'h0002);
`endif
    check("t5_rdn_low",  16'(rdn_low),  16'd0);

    // Status read: transmitter idle, nothing received.
    run_access(1'b0, 1'b1, 16'h0000, 0, 0, 1'b0, 16'h0000, 4);
    check("t5b_rdata", done_rdata, 16'h0001);

`ifndef UART_RX_FIFO_EN
    // Data read with a byte waiting: bus carries 0xA55A.
    run_access(1'b0, 1'b0, 16'h0000, 0, 0, 1'b1, 16'hA55A, 8);
    check("t3_rdn_cycles", 16'(rdn_low),  16'd2);
    check("t3_done_cnt",   16'(done_cnt), 16'd1);
    check("t3_done_cyc",   16'(done_cyc), 16'd4);
    check("t3_rdata",      done_rdata,    16'h005A);

    // Data read with nothing waiting.
    run_access(1'b0, 1'b0, 16'h0000, 0, 0, 1'b0, 16'hBEEF, 4);
    check("t4_rdn_cycles", 16'(rdn_low),  16'd0);
    check("t4_done_cyc",   16'(done_cyc), 16'd1);
    check("t4_rdata",      done_rdata,    16'h0000);
    check("t4_rdata_hold", rdata,         16'h0000);
`else
    // Five bytes arrive with no requests: four are drained, the fifth stays.
    begin
      int busy_cnt, dn_cnt, rl_cnt;
      busy_cnt = 0; dn_cnt = 0; rl_cnt = 0;
      @(posedge clk); #1;
      for (int i = 1; i <= 5; i++) chip_q.push_back(8'(i));
      rdn_prev = 1'b1;
      chip_mode = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #2;
        if (busy) busy_cnt++;
        if (done) dn_cnt++;
        if (!rdn) rl_cnt++;
      end
      check("t6_left_in_uart", 16'(chip_q.size()), 16'd1);
      check("t6_rdn_cycles",   16'(rl_cnt),        16'd8);
      check("t6_busy_cnt",     16'(busy_cnt),      16'd0);
      check("t6_done_cnt",     16'(dn_cnt),        16'd0);
    end
    run_access(1'b0, 1'b0, 16'h0000, 0, 0, 1'b0, 16'h0000, 12);
    check("t6_rd1_cyc", 16'(done_cyc), 16'd1);
    check("t6_rd1",     done_rdata,    16'h0001);
    run_access(1'b0, 1'b0, 16'h0000, 0, 0, 1'b0, 16'h0000, 12);
    check("t6_rd2", done_rdata, 16'h0002);
    check("t6_rd2_cnt", 16'(done_cnt), 16'd1);
    run_access(1'b0, 1'b0, 16'h0000, 0, 0, 1'b0, 16'h0000, 12);
    check("t6_rd3", done_rdata, 16'h0003);
    run_access(1'b0, 1'b0, 16'h0000, 0, 0, 1'b0, 16'h0000, 12);
    check("t6_rd4", done_rdata, 16'h0004);
    run_access(1'b0, 1'b0, 16'h0000, 0, 0, 1'b0, 16'h0000, 12);
    check("t6_rd5", done_rdata, 16'h0005);
    check("t6_uart_empty", 16'(chip_q.size()), 16'd0);
    run_access(1'b0, 1'b0, 16'h0000, 0, 0, 1'b0, 16'h0000, 12);
    check("t6_rd_empty", done_rdata, 16'h0000);
    check("t6_rd_empty_cnt", 16'(done_cnt), 16'd1);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
